mouse_tracker: RTL and testbench

Parametrised, fully synchronous PS/2 mouse position tracker. It accepts decoded movement packets from the PS/2 packet decoder over a valid/ready handshake. It scales and accumulates X/Y movement into signed position registers, with optional clamping to a programmable window. Button transitions are queued in an event FIFO, and everything sits on the CPU's 8-bit-address register bus.

---
 rtl/mouse_tracker.sv | 155 +++++++++++++++
 tb/tb_mouse_tracker.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_tracker.sv
// mouse_tracker: PS/2 mouse position tracker with per-axis scaling, optional window
// clamping and a button-event FIFO, all on an 8-bit-address register bus.
module mouse_tracker #(
    parameter int POS_W      = 32,
    parameter int SCALE_W    = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [7:0]  Addr,
    input  logic [31:0] WrData,
    output logic [31:0] RdData,
    input  logic        RD,
    input  logic        WR,
    input  logic        PktValid,
    output logic        PktReady,
    input  logic [2:0]  PktButtons,
    input  logic [8:0]  PktDx,
    input  logic [8:0]  PktDy,
    output logic        Irq
);
    localparam int PW = 10 + SCALE_W;
    localparam int SW = POS_W + 2;
    localparam int AW = $clog2(FIFO_DEPTH);

    // Add in POS_W+2 bits so saturation sees the true sum; MIN>MAX collapses to MIN.
    function automatic logic [POS_W-1:0] step(input logic [POS_W-1:0] pos, input logic [PW-1:0] prod,
                                              input logic [POS_W-1:0] lo, input logic [POS_W-1:0] hi,
                                              input logic clamp);
        logic signed [SW-1:0] s, l, h;
        s = SW'($signed(pos)) + SW'($signed(prod));
        l = SW'($signed(lo));
        h = SW'($signed(hi));
        return !clamp ? s[POS_W-1:0] : (l > h || s < l) ? lo : s > h ? hi : s[POS_W-1:0];
    endfunction

    logic [POS_W-1:0]   pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [POS_W-1:0]   min_x_q, min_x_d, max_x_q, max_x_d, min_y_q, min_y_d, max_y_q, max_y_d;
    logic [SCALE_W-1:0] scale_x_q, scale_x_d, scale_y_q, scale_y_d;
    logic [3:0]         ctrl_q, ctrl_d;
    logic [2:0]         btn_q, btn_d;
    logic [8:0]         dx_q, dx_d, dy_q, dy_d;
    logic               in_v_q, in_v_d, p_v_q, p_v_d, ovf_q, ovf_d;
    logic [PW-1:0]      px_q, px_d, py_q, py_d, mx, my;
    logic [AW:0]        rp_q, rp_d, wp_q, wp_d;
    logic [31:0]        rdata_q, rdata_d, rmux;
    logic [5:0]         mem_q [FIFO_DEPTH];
    logic               accept, empty, full, push, pop, push_ok, wr_px, wr_py, rd_st;

    assign PktReady = ctrl_q[0] & ~in_v_q & ~Reset;
    assign accept   = PktValid & PktReady;
    assign empty    = rp_q == wp_q;
    assign full     = (rp_q[AW] != wp_q[AW]) && (rp_q[AW-1:0] == wp_q[AW-1:0]);
    assign push     = accept && PktButtons != btn_q;
    assign pop      = RD && Addr == 8'h0A && !empty;
    assign push_ok  = push && (!full || pop);
    assign rd_st    = RD && Addr == 8'h02;
    assign wr_px    = WR && Addr == 8'h00;
    assign wr_py    = WR && Addr == 8'h01;
    assign Irq      = ctrl_q[3] & (~empty | ovf_q);
    assign RdData   = rdata_q;
    assign mx       = PW'($signed(dx_q)) * PW'(scale_x_q);
    assign my       = PW'($signed(dy_q)) * PW'(scale_y_q);

    always_comb begin
        rmux = '0;
        case (Addr)
            8'h00:   rmux = 32'($signed(pos_x_q));
            8'h01:   rmux = 32'($signed(pos_y_q));
            8'h02:   rmux = {26'b0, ovf_q, full, empty, btn_q};
            8'h03:   rmux = 32'(scale_x_q);
            8'h04:   rmux = 32'(scale_y_q);
            8'h05:   rmux = 32'($signed(min_x_q));
            8'h06:   rmux = 32'($signed(max_x_q));
            8'h07:   rmux = 32'($signed(min_y_q));
            8'h08:   rmux = 32'($signed(max_y_q));
            8'h09:   rmux = {28'b0, ctrl_q};
            8'h0A:   rmux = empty ? 32'b0 : {1'b1, 25'b0, mem_q[rp_q[AW-1:0]]};
            default: rmux = '0;
        endcase
    end

    always_comb begin
        in_v_d    = accept;
        dx_d      = accept ? PktDx : dx_q;
        dy_d      = accept ? PktDy : dy_q;
        p_v_d     = in_v_q;
        px_d      = in_v_q ? mx : px_q;
        py_d      = in_v_q ? (ctrl_q[2] ? -my : my) : py_q;
        pos_x_d   = wr_px ? WrData[POS_W-1:0] : p_v_q ? step(pos_x_q, px_q, min_x_q, max_x_q, ctrl_q[1]) : pos_x_q;
        pos_y_d   = wr_py ? WrData[POS_W-1:0] : p_v_q ? step(pos_y_q, py_q, min_y_q, max_y_q, ctrl_q[1]) : pos_y_q;
        scale_x_d = WR && Addr == 8'h03 ? WrData[SCALE_W-1:0] : scale_x_q;
        scale_y_d = WR && Addr == 8'h04 ? WrData[SCALE_W-1:0] : scale_y_q;
        min_x_d   = WR && Addr == 8'h05 ? WrData[POS_W-1:0] : min_x_q;
        max_x_d   = WR && Addr == 8'h06 ? WrData[POS_W-1:0] : max_x_q;
        min_y_d   = WR && Addr == 8'h07 ? WrData[POS_W-1:0] : min_y_q;
        max_y_d   = WR && Addr == 8'h08 ? WrData[POS_W-1:0] : max_y_q;
        ctrl_d    = WR && Addr == 8'h09 ? WrData[3:0] : ctrl_q;
        btn_d     = accept ? PktButtons : btn_q;
        rp_d      = rp_q + (AW+1)'(pop);
        wp_d      = wp_q + (AW+1)'(push_ok);
        ovf_d     = (ovf_q & ~rd_st) | (push & ~push_ok);
        rdata_d   = RD ? rmux : rdata_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pos_x_q   <= '0;
            pos_y_q   <= '0;
            scale_x_q <= SCALE_W'(1);
            scale_y_q <= SCALE_W'(1);
            min_x_q   <= {1'b1, {(POS_W-1){1'b0}}};
            max_x_q   <= {1'b0, {(POS_W-1){1'b1}}};
            min_y_q   <= {1'b1, {(POS_W-1){1'b0}}};
            max_y_q   <= {1'b0, {(POS_W-1){1'b1}}};
            ctrl_q    <= 4'h1;
            btn_q     <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            in_v_q    <= 1'b0;
            p_v_q     <= 1'b0;
            px_q      <= '0;
            py_q      <= '0;
            rp_q      <= '0;
            wp_q      <= '0;
            ovf_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            scale_x_q <= scale_x_d;
            scale_y_q <= scale_y_d;
            min_x_q   <= min_x_d;
            max_x_q   <= max_x_d;
            min_y_q   <= min_y_d;
            max_y_q   <= max_y_d;
            ctrl_q    <= ctrl_d;
            btn_q     <= btn_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            in_v_q    <= in_v_d;
            p_v_q     <= p_v_d;
            px_q      <= px_d;
            py_q      <= py_d;
            rp_q      <= rp_d;
            wp_q      <= wp_d;
            ovf_q     <= ovf_d;
            rdata_q   <= rdata_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (push_ok) mem_q[wp_q[AW-1:0]] <= {btn_q, PktButtons};
    end
endmodule

// File: tb/tb_mouse_tracker.sv
// tb_mouse_tracker: randomized and directed checks of mouse_tracker against a
// transaction-level model of positions, registers and the button-event queue.
module tb_mouse_tracker;
    localparam int DEPTH = 8;

    logic        Clk = 0, Reset = 1, RD = 0, WR = 0, PktValid = 0;
    logic [7:0]  Addr = 0;
    logic [31:0] WrData = 0, RdData;
    logic        PktReady, Irq;
    logic [2:0]  PktButtons = 0;
    logic [8:0]  PktDx = 0, PktDy = 0;

    mouse_tracker dut (
        .Clk(Clk), .Reset(Reset), .Addr(Addr), .WrData(WrData), .RdData(RdData),
        .RD(RD), .WR(WR), .PktValid(PktValid), .PktReady(PktReady),
        .PktButtons(PktButtons), .PktDx(PktDx), .PktDy(PktDy), .Irq(Irq)
    );

    always #5 Clk = ~Clk;

    int          n_chk = 0, n_pass = 0;
    longint      mpx, mpy, mminx, mmaxx, mminy, mmaxy;
    int          msx, msy;
    logic [3:0]  mctrl;
    logic [2:0]  mbtn;
    logic [5:0]  mq[$];
    logic        movf;
    logic [31:0] last;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic mreset;
        mpx = 0; mpy = 0; msx = 1; msy = 1;
        mminx = -64'sd2147483648; mmaxx = 64'sd2147483647;
        mminy = -64'sd2147483648; mmaxy = 64'sd2147483647;
        mctrl = 4'h1; mbtn = 0; mq.delete(); movf = 0;
    endtask

    function automatic longint sx32(input logic [31:0] d);
        return longint'($signed(d));
    endfunction

    // New position from old position plus scaled delta, per the window rules.
    function automatic longint step(input longint p, input longint d, input longint lo, input longint hi, input logic cl);
        longint s;
        s = p + d;
        if (cl) return (lo > hi) ? lo : (s < lo) ? lo : (s > hi) ? hi : s;
        return sx32(s[31:0]);
    endfunction

    function automatic logic [31:0] exp_reg(input logic [7:0] a);
        case (a)
            8'h00: return 32'(mpx);
            8'h01: return 32'(mpy);
            8'h02: return {26'b0, movf, mq.size() == DEPTH, mq.size() == 0, mbtn};
            8'h03: return 32'(msx);
            8'h04: return 32'(msy);
            8'h05: return 32'(mminx);
            8'h06: return 32'(mmaxx);
            8'h07: return 32'(mminy);
            8'h08: return 32'(mmaxy);
            8'h09: return {28'b0, mctrl};
            8'h0A: return (mq.size() != 0) ? {1'b1, 25'b0, mq[0]} : 32'b0;
            default: return 32'b0;
        endcase
    endfunction

    task automatic mread(input logic [7:0] a);
        if (a == 8'h02) movf = 0;
        if (a == 8'h0A && mq.size() != 0) void'(mq.pop_front());
    endtask

    task automatic mpkt(input logic [2:0] b, input logic [8:0] dx, input logic [8:0] dy);
        longint d;
        mpx = step(mpx, longint'($signed(dx)) * msx, mminx, mmaxx, mctrl[1]);
        d = longint'($signed(dy)) * msy;
        if (mctrl[2]) d = -d;
        mpy = step(mpy, d, mminy, mmaxy, mctrl[1]);
        if (b != mbtn) begin
            if (mq.size() < DEPTH) mq.push_back({mbtn, b});
            else movf = 1;
            mbtn = b;
        end
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a);
        logic [31:0] e;
        e = exp_reg(a);
        @(negedge Clk); RD = 1; Addr = a;
        @(negedge Clk); RD = 0;
        last = RdData;
        chk(tag, RdData, e);
        mread(a);
        chk({tag, "_irq"}, {31'b0, Irq}, {31'b0, mctrl[3] & (mq.size() != 0 | movf)});
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge Clk); WR = 1; Addr = a; WrData = d;
        @(negedge Clk); WR = 0;
        case (a)
            8'h00: mpx = sx32(d);
            8'h01: mpy = sx32(d);
            8'h03: msx = int'(d[7:0]);
            8'h04: msy = int'(d[7:0]);
            8'h05: mminx = sx32(d);
            8'h06: mmaxx = sx32(d);
            8'h07: mminy = sx32(d);
            8'h08: mmaxy = sx32(d);
            8'h09: mctrl = d[3:0];
            default: ;
        endcase
    endtask

    task automatic send(input logic [2:0] b, input logic [8:0] dx, input logic [8:0] dy);
        int t;
        t = 0;
        @(negedge Clk);
        while (!PktReady && t < 20) begin
            @(negedge Clk);
            t++;
        end
        if (!PktReady) begin
            chk("ready_timeout", {31'b0, PktReady}, 32'd1);
            return;
        end
        PktValid = 1; PktButtons = b; PktDx = dx; PktDy = dy;
        @(negedge Clk); PktValid = 0;
        @(negedge Clk);
        @(negedge Clk);
        mpkt(b, dx, dy);
    endtask

    task automatic check_all;
        for (int a = 0; a <= 10; a++) rd_chk($sformatf("reg%0d", a), 8'(a));
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r, ax, lo, hi;
        logic [31:0] v, e;
        mreset();
        repeat (3) @(negedge Clk);
        chk("ready_in_reset", {31'b0, PktReady}, 32'd0);
        chk("irq_reset", {31'b0, Irq}, 32'd0);
        chk("rdata_reset", RdData, 32'd0);
        Reset = 0;
        check_all();
        rd_chk("status_rst", 8'h02); chk("status_rst_val", last, 32'h08);
        rd_chk("minx_rst", 8'h05);   chk("minx_rst_val", last, 32'h80000000);
        rd_chk("maxx_rst", 8'h06);   chk("maxx_rst_val", last, 32'h7FFFFFFF);

        // Scaling and invert_y
        wr(8'h03, 3);
        send(0, 9'h1FE, 9'd5);
        rd_chk("px_scale", 8'h00); chk("px_scale_val", last, 32'hFFFFFFFA);
        rd_chk("py_scale", 8'h01); chk("py_scale_val", last, 32'd5);
        wr(8'h09, 32'h5);
        send(0, 9'h1FE, 9'd5);
        rd_chk("py_inv", 8'h01); chk("py_inv_val", last, 32'd0);
        wr(8'h09, 1); wr(8'h03, 1);

        // Clamping and wrapping
        wr(8'h09, 3); wr(8'h05, 0); wr(8'h06, 100); wr(8'h00, 95);
        send(0, 9'd20, 0);
        rd_chk("clamp_hi", 8'h00); chk("clamp_hi_val", last, 32'd100);
        send(0, 9'h101, 0);
        rd_chk("clamp_lo", 8'h00); chk("clamp_lo_val", last, 32'd0);
        wr(8'h09, 1); wr(8'h00, 32'h7FFFFFFF);
        send(0, 9'd1, 0);
        rd_chk("wrap", 8'h00); chk("wrap_val", last, 32'h80000000);
        wr(8'h05, 32'h80000000); wr(8'h06, 32'h7FFFFFFF);

        // FIFO overflow, sticky flag and ordered pops
        wr(8'h09, 9);
        for (int k = 0; k <= DEPTH; k++) send((k % 2 == 0) ? 3'd1 : 3'd0, 0, 0);
        rd_chk("st_full", 8'h02); chk("st_full_val", last, 32'h31);
        rd_chk("st_clr", 8'h02);  chk("st_clr_val", last, 32'h11);
        for (int k = 0; k < DEPTH; k++) begin
            rd_chk("pop", 8'h0A);
            chk("pop_val", last, (k % 2 == 0) ? 32'h80000001 : 32'h80000008);
        end
        rd_chk("pop_empty", 8'h0A); chk("pop_empty_val", last, 32'd0);

        // Pop and push on the same edge while full
        for (int k = 0; k < DEPTH; k++) send((k % 2 == 0) ? 3'd0 : 3'd1, 0, 0);
        e = exp_reg(8'h0A);
        @(negedge Clk);
        PktValid = 1; PktButtons = 3'd4; PktDx = 0; PktDy = 0; RD = 1; Addr = 8'h0A;
        @(negedge Clk); PktValid = 0; RD = 0;
        chk("pushpop_rd", RdData, e);
        mread(8'h0A);
        mpkt(3'd4, 0, 0);
        @(negedge Clk);
        rd_chk("pushpop_st", 8'h02); chk("pushpop_st_val", last, 32'h14);
        for (int k = 0; k <= DEPTH; k++) rd_chk("drain", 8'h0A);

        // Bus write to POS_X on the S2 edge
        @(negedge Clk);
        chk("coll_rdy0", {31'b0, PktReady}, 32'd1);
        PktValid = 1; PktButtons = mbtn; PktDx = 9'd7; PktDy = 9'd3;
        @(negedge Clk); PktValid = 0;
        chk("coll_rdy1", {31'b0, PktReady}, 32'd0);
        @(negedge Clk);
        chk("coll_rdy2", {31'b0, PktReady}, 32'd1);
        WR = 1; Addr = 8'h00; WrData = 32'h1234;
        @(negedge Clk); WR = 0;
        mpkt(mbtn, 9'd7, 9'd3);
        mpx = 32'h1234;
        rd_chk("coll_px", 8'h00); chk("coll_px_val", last, 32'h1234);
        rd_chk("coll_py", 8'h01);

        // Back-to-back PktValid
        @(negedge Clk);
        PktValid = 1; PktButtons = mbtn; PktDx = 9'd1; PktDy = 9'd0;
        for (int k = 0; k < 6; k++) begin
            chk("b2b_ready", {31'b0, PktReady}, (k % 2 == 0) ? 32'd1 : 32'd0);
            @(negedge Clk);
        end
        PktValid = 0;
        repeat (3) mpkt(mbtn, 9'd1, 9'd0);
        @(negedge Clk);
        rd_chk("b2b_px", 8'h00);

        // Reset with a packet in flight
        wr(8'h03, 5); wr(8'h09, 32'hF);
        @(negedge Clk);
        PktValid = 1; PktButtons = 3'd2; PktDx = 9'd5; PktDy = 9'd5;
        @(negedge Clk); PktValid = 0; Reset = 1;
        @(negedge Clk);
        chk("rst_ready", {31'b0, PktReady}, 32'd0);
        @(negedge Clk); Reset = 0;
        mreset();
        check_all();

        // Randomized register traffic and packets
        for (int it = 0; it < 80; it++) begin
            r = $urandom_range(0, 9);
            ax = $urandom_range(0, 1);
            if (r == 0) wr(8'(3 + ax), ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 255)));
            else if (r == 1) wr(8'h09, {28'b0, 3'($urandom_range(0, 7)), 1'b1});
            else if (r == 2) begin
                lo = $urandom_range(0, 2000) - 1000;
                hi = $urandom_range(0, 2000) - 1000;
                wr(8'(5 + 2 * ax), 32'(lo));
                wr(8'(6 + 2 * ax), 32'(hi));
            end else if (r == 3) begin
                v = ($urandom_range(0, 3) == 0) ? 32'h7FFFFF80 : 32'($urandom_range(0, 2000) - 1000);
                wr(8'(ax), v);
            end else if (r <= 7) send(3'($urandom_range(0, 7)), 9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)));
            else if (r == 8) rd_chk("rnd_status", 8'h02);
            else rd_chk("rnd_event", 8'h0A);
            rd_chk("rnd_px", 8'h00);
            rd_chk("rnd_py", 8'h01);
        end
        check_all();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
